mod_arith_pipe: RTL and testbench

//  Parametrised two-stage arithmetic pipeline; successor to the single-cycle add task / mult function.

---
 rtl/mod_arith_pipe.sv | 122 ++++++++++++
 tb/tb_mod_arith_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_arith_pipe.sv
// Two-stage arithmetic pipeline: ADD / MULT / saturating MAC / CLR with
// valid/ready handshake on both sides. S1 registers the accepted operand
// beat, S2 computes and holds the result. The whole pipe advances together
// whenever the output register is empty or being drained.
module mod_arith_pipe #(
  parameter  int WIDTH     = 8,
  parameter  int ACC_GUARD = 4,
  localparam int ACC_W     = 2*WIDTH + ACC_GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             acc_ovf
);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_MULT = 2'd1;
  localparam logic [1:0] OP_MAC  = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  logic             adv;
  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;

  logic [WIDTH:0]     sum_ab;
  logic [2*WIDTH-1:0] prod_ab;
  logic [ACC_W:0]     mac_sum;

  assign adv       = out_ready || !out_valid_q;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign acc_ovf   = acc_ovf_q;

  // Stage 1: capture an accepted beat, or a bubble when nothing transfers.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op;
        s1_a_d  = a;
        s1_b_d  = b;
      end
    end
  end

  // Stage 2 datapath: arithmetic on the S1 operands and the saturating accumulator.
  always_comb begin
    sum_ab      = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    prod_ab     = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
    mac_sum     = {1'b0, acc_q} + (ACC_W+1)'(prod_ab);
    out_valid_d = out_valid_q;
    result_d    = result_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        case (s1_op_q)
          OP_ADD:  result_d = ACC_W'(sum_ab);
          OP_MULT: result_d = ACC_W'(prod_ab);
          OP_MAC: begin
            if (mac_sum[ACC_W]) begin
              acc_d     = '1;
              acc_ovf_d = 1'b1;
            end else begin
              acc_d = mac_sum[ACC_W-1:0];
            end
            result_d = acc_d;
          end
          OP_CLR: begin
            acc_d     = '0;
            acc_ovf_d = 1'b0;
            result_d  = '0;
          end
          default: result_d = result_q;
        endcase
      end
    end
  end

  // Pipeline registers; reset discards in-flight beats and clears the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

endmodule

// File: tb/tb_mod_arith_pipe.sv
// Directed vector table, hand-written stall/reset sequences and a random
// handshake run for mod_arith_pipe (WIDTH=8, ACC_GUARD=4).
module tb_mod_arith_pipe;

  localparam int WIDTH = 8;
  localparam int ACC_W = 20;
  localparam logic [1:0] ADD = 2'd0, MULT = 2'd1, MAC = 2'd2, CLR = 2'd3;
  localparam longint SAT = 1048575;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             acc_ovf;

  mod_arith_pipe #(.WIDTH(8), .ACC_GUARD(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [ACC_W-1:0] res;
    logic             ovf;
  } vec_t;

  vec_t   tbl[$];
  longint exp_res[$];
  bit     exp_ovf[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_out = 0;
  bit     s_ov, s_ir;
  longint s_res;
  longint m_acc = 0;
  bit     m_ovf = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour of one committed beat.
  function automatic void model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                output longint r, output bit f);
    longint p;
    p = longint'(x) * longint'(y);
    case (o)
      ADD:  r = longint'(x) + longint'(y);
      MULT: r = p;
      MAC: begin
        if (m_acc + p > SAT) begin
          m_acc = SAT;
          m_ovf = 1'b1;
        end else begin
          m_acc = m_acc + p;
        end
        r = m_acc;
      end
      default: begin
        m_acc = 0;
        m_ovf = 1'b0;
        r     = 0;
      end
    endcase
    f = m_ovf;
  endfunction

  // One clock: drive at the falling edge, sample 1ns later, score any output transfer.
  task automatic cyc(input bit iv, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                     input bit ordy, output bit took);
    longint er;
    bit     eo;
    @(negedge clk);
    in_valid  = iv;
    op        = o;
    a         = x;
    b         = y;
    out_ready = ordy;
    #1;
    s_ov  = out_valid;
    s_ir  = in_ready;
    s_res = longint'(result);
    took  = iv && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0d, expected no output", result);
      end else begin
        er = exp_res.pop_front();
        eo = exp_ovf.pop_front();
        check("result", longint'(result), er);
        check("acc_ovf", longint'(acc_ovf), longint'(eo));
      end
    end
  endtask

  task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      input longint er, input bit eo);
    bit took;
    int k;
    took = 1'b0;
    k    = 0;
    while (!took && k < 50) begin
      cyc(1'b1, o, x, y, 1'b1, took);
      k++;
    end
    if (took) begin
      exp_res.push_back(er);
      exp_ovf.push_back(eo);
    end else begin
      check("send_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    bit t;
    int k;
    k = 0;
    while ((exp_res.size() != 0 || out_valid) && k < 100) begin
      cyc(1'b0, ADD, 8'd0, 8'd0, 1'b1, t);
      k++;
    end
    if (exp_res.size() != 0) begin
      check("drain_timeout", exp_res.size(), 0);
      exp_res.delete();
      exp_ovf.delete();
    end
  endtask

  initial begin
    bit     t;
    int     n0, beats, cycles;
    bit     pend;
    logic [1:0] po;
    logic [7:0] pa, pb;
    longint er;
    bit     eo;

    // Vector table
    tbl.push_back('{CLR,  8'd0,   8'd0,   20'd0,     1'b0});
    tbl.push_back('{MULT, 8'd255, 8'd255, 20'd65025, 1'b0});
    tbl.push_back('{ADD,  8'd3,   8'd4,   20'd7,     1'b0});
    tbl.push_back('{ADD,  8'd0,   8'd0,   20'd0,     1'b0});
    tbl.push_back('{ADD,  8'd255, 8'd0,   20'd255,   1'b0});
    tbl.push_back('{MULT, 8'd0,   8'd200, 20'd0,     1'b0});
    tbl.push_back('{MULT, 8'd16,  8'd16,  20'd256,   1'b0});
    tbl.push_back('{MAC,  8'd10,  8'd20,  20'd200,   1'b0});
    tbl.push_back('{ADD,  8'd1,   8'd1,   20'd2,     1'b0});
    tbl.push_back('{MAC,  8'd3,   8'd4,   20'd212,   1'b0});
    tbl.push_back('{CLR,  8'd0,   8'd0,   20'd0,     1'b0});
    for (int k = 1; k <= 16; k++)
      tbl.push_back('{MAC, 8'd255, 8'd255, 20'(65025*k), 1'b0});
    tbl.push_back('{MAC,  8'd255, 8'd255, 20'd1048575, 1'b1});
    tbl.push_back('{ADD,  8'd255, 8'd255, 20'd510,     1'b1});
    tbl.push_back('{MAC,  8'd0,   8'd0,   20'd1048575, 1'b1});
    tbl.push_back('{CLR,  8'd0,   8'd0,   20'd0,       1'b0});
    tbl.push_back('{MAC,  8'd1,   8'd1,   20'd1,       1'b0});

    rst = 1'b1; in_valid = 1'b0; op = ADD; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_result", longint'(result), 0);
    check("reset_acc_ovf", longint'(acc_ovf), 0);
    check("reset_in_ready", longint'(in_ready), 1);

    // Latency: ADD 255+255 visible two cycles after transfer
    cyc(1'b1, ADD, 8'd255, 8'd255, 1'b1, t);
    check("lat_took", longint'(t), 1);
    if (t) begin exp_res.push_back(510); exp_ovf.push_back(1'b0); end
    cyc(1'b0, ADD, 8'd0, 8'd0, 1'b1, t);
    check("lat_cycle1_out_valid", longint'(s_ov), 0);
    cyc(1'b0, ADD, 8'd0, 8'd0, 1'b1, t);
    check("lat_cycle2_out_valid", longint'(s_ov), 1);
    drain();

    // Table run, back-to-back beats
    for (int i = 0; i < tbl.size(); i++)
      send(tbl[i].op, tbl[i].a, tbl[i].b, longint'(tbl[i].res), tbl[i].ovf);
    drain();

    // Stall: consumer blocks for 5 cycles while 3 beats are offered
    n0 = n_out;
    cyc(1'b1, ADD, 8'd1, 8'd1, 1'b0, t);
    check("stall_take1", longint'(t), 1);
    if (t) begin exp_res.push_back(2); exp_ovf.push_back(1'b0); end
    cyc(1'b1, MULT, 8'd3, 8'd5, 1'b0, t);
    check("stall_take2", longint'(t), 1);
    if (t) begin exp_res.push_back(15); exp_ovf.push_back(1'b0); end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, ADD, 8'd100, 8'd27, 1'b0, t);
      check("stall_in_ready", longint'(s_ir), 0);
      check("stall_out_valid", longint'(s_ov), 1);
      check("stall_result_hold", s_res, 2);
    end
    send(ADD, 8'd100, 8'd27, 127, 1'b0);
    drain();
    check("stall_count", n_out - n0, 3);

    // Saturate, then reset with two MACs in flight
    send(CLR, 8'd0, 8'd0, 0, 1'b0);
    for (int k = 1; k <= 17; k++)
      send(MAC, 8'd255, 8'd255, (k <= 16) ? longint'(65025*k) : SAT, k > 16);
    drain();
    check("pre_rst_acc_ovf", longint'(acc_ovf), 1);
    cyc(1'b1, MAC, 8'd10, 8'd10, 1'b1, t);
    cyc(1'b1, MAC, 8'd2, 8'd2, 1'b1, t);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", longint'(out_valid), 0);
    check("rst_mid_acc_ovf", longint'(acc_ovf), 0);
    check("rst_mid_result", longint'(result), 0);
    check("rst_mid_in_ready", longint'(in_ready), 1);
    n0 = n_out;
    send(MAC, 8'd2, 8'd3, 6, 1'b0);
    drain();
    check("rst_mid_flush_count", n_out - n0, 1);

    // Random handshake run against the model
    beats = 0; cycles = 0; pend = 1'b0;
    po = CLR; pa = '0; pb = '0;
    while (beats < 1000 && cycles < 30000) begin
      if (!pend) begin
        int r;
        r  = int'($urandom_range(0, 31));
        po = (beats == 0 || r == 31) ? CLR : (r < 8) ? ADD : (r < 16) ? MULT : MAC;
        pa = ($urandom_range(0, 3) != 0) ? 8'd255 : 8'($urandom_range(0, 255));
        pb = ($urandom_range(0, 3) != 0) ? 8'd255 : 8'($urandom_range(0, 255));
        pend = ($urandom_range(0, 3) != 0);
      end
      cyc(pend, po, pa, pb, $urandom_range(0, 2) != 0, t);
      if (t) begin
        model(po, pa, pb, er, eo);
        exp_res.push_back(er);
        exp_ovf.push_back(eo);
        beats++;
        pend = 1'b0;
      end
      cycles++;
    end
    check("random_beats", beats, 1000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
